mac_core: RTL and testbench

//  Pipelined signed multiply-accumulate core for streaming dot products.

---
 rtl/mac_core_if.sv | 25 ++
 rtl/mac_core.sv | 81 ++++++++
 tb/tb_mac_core.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_core_if.sv
// Streaming sample bus for mac_core: clock enable, qualified operand pair in,
// registered running sum and its update strobe out.
interface mac_core_if #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 18
);
    logic                        enable;
    logic                        valid_in;
    logic signed [A_WIDTH-1:0]   a;
    logic signed [B_WIDTH-1:0]   b;
    logic                        eof;
    logic signed [OUT_WIDTH-1:0] result;
    logic                        valid_out;

    modport master (
        output enable, valid_in, a, b, eof,
        input  result, valid_out
    );

    modport slave (
        input  enable, valid_in, a, b, eof,
        output result, valid_out
    );
endinterface

// File: rtl/mac_core.sv
// Three-stage signed multiply-accumulate (input, product, accumulator) under a
// global clock enable. Define MAC_SATURATE_EN to clamp instead of wrap on overflow.
module mac_core #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 18
) (
    input  logic      clk,
    input  logic      reset,
    mac_core_if.slave bus
);
    localparam int PW = A_WIDTH + B_WIDTH;

    logic signed [A_WIDTH-1:0]   s1_a;
    logic signed [B_WIDTH-1:0]   s1_b;
    logic                        s1_valid;
    logic                        s1_eof;
    logic signed [OUT_WIDTH-1:0] s2_prod;
    logic                        s2_valid;
    logic                        s2_eof;
    logic signed [OUT_WIDTH-1:0] acc;
    logic                        vout;
    logic                        start;

    logic signed [PW-1:0]        mult;
    logic signed [OUT_WIDTH-1:0] prod_ext;
    logic signed [OUT_WIDTH-1:0] sum_next;

    // Operands are widened before the multiply so the product is exact at PW bits.
    assign mult     = PW'(s1_a) * PW'(s1_b);
    assign prod_ext = OUT_WIDTH'(mult);

`ifdef MAC_SATURATE_EN
    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    logic signed [OUT_WIDTH:0] sum_wide;

    always_comb begin
        sum_wide = (OUT_WIDTH+1)'(acc) + (OUT_WIDTH+1)'(s2_prod);
        sum_next = sum_wide[OUT_WIDTH-1:0];
        if (sum_wide[OUT_WIDTH] != sum_wide[OUT_WIDTH-1])
            sum_next = sum_wide[OUT_WIDTH] ? SAT_MIN : SAT_MAX;
    end
`else
    always_comb begin
        sum_next = acc + s2_prod;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s1_valid <= 1'b0;
            s1_eof   <= 1'b0;
            s2_prod  <= '0;
            s2_valid <= 1'b0;
            s2_eof   <= 1'b0;
            acc      <= '0;
            vout     <= 1'b0;
            start    <= 1'b1;
        end else if (bus.enable) begin
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_valid <= bus.valid_in;
            s1_eof   <= bus.eof;
            s2_prod  <= prod_ext;
            s2_valid <= s1_valid;
            s2_eof   <= s1_valid & s1_eof;
            vout     <= s2_valid;
            // The start flag lives at the accumulator so back-to-back frames need no gap.
            if (s2_valid) begin
                acc   <= start ? s2_prod : sum_next;
                start <= s2_eof;
            end
        end
    end

    assign bus.result    = acc;
    assign bus.valid_out = vout;
endmodule

// File: tb/tb_mac_core.sv
// Scoreboard bench for mac_core: the driver pushes model sums, the monitor pops
// and compares on every enabled valid_out pulse.
module tb_mac_core;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int OW = 18;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_core_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus ();
    mac_core #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    longint exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     pulses      = 0;
    longint m_acc       = 0;
    bit     m_start     = 1'b1;
    longint last_exp    = 0;
    logic   en_q        = 1'b0;
    logic   rst_q       = 1'b1;

`ifdef MAC_SATURATE_EN
    localparam longint OVF_EXP = 131071;
`else
    localparam longint OVF_EXP = 60436;
`endif

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic longint fix(input longint s);
        longint r;
`ifdef MAC_SATURATE_EN
        r = s;
        if (r > 131071)  r = 131071;
        if (r < -131072) r = -131072;
`else
        r = s & 64'd262143;
        if (r >= 131072) r = r - 262144;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        en_q  <= bus.enable;
        rst_q <= reset;
    end

    always @(negedge clk) begin
        if (!rst_q) begin
            if (en_q && bus.valid_out) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_pulse: got result %0d, required no pulse", longint'(bus.result));
                end else begin
                    last_exp = exp_q.pop_front();
                    check("result", longint'(bus.result), last_exp);
                end
            end else if (!en_q) begin
                check("stall_hold", longint'(bus.result), last_exp);
            end
        end
    end

    task automatic send(input int a, input int b, input bit e);
        longint p, s;
        @(posedge clk); #1;
        bus.enable   = 1'b1;
        bus.valid_in = 1'b1;
        bus.a        = AW'(a);
        bus.b        = BW'(b);
        bus.eof      = e;
        p = longint'(a) * longint'(b);
        s = fix(m_start ? p : m_acc + p);
        m_acc   = s;
        m_start = e;
        exp_q.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.enable   = 1'b1;
            bus.valid_in = 1'b0;
            bus.eof      = 1'b0;
        end
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.enable   = 1'b0;
            bus.valid_in = 1'b1;
            bus.a        = 8'sd99;
            bus.b        = 8'sd99;
            bus.eof      = 1'b1;
        end
    endtask

    task automatic drain(input string name, input longint final_sum, input int npulses);
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (exp_q.size() == 0) break;
        end
        idle(2);
        check({name, "_pending"}, exp_q.size(), 0);
        @(negedge clk); #1;
        check({name, "_final"}, longint'(bus.result), final_sum);
        check({name, "_pulses"}, pulses, npulses);
        pulses = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.valid_in = 1'b1;
        bus.a        = 8'sd5;
        bus.b        = 8'sd5;
        @(posedge clk); #1;
        exp_q.delete();
        m_acc    = 0;
        m_start  = 1'b1;
        last_exp = 0;
        check("reset_result", longint'(bus.result), 0);
        check("reset_valid_out", longint'(bus.valid_out), 0);
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        pulses       = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.valid_in = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.eof      = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        idle(1);

        // single 15-sample frame with bubbles
        for (int i = 1; i <= 15; i++) begin
            send(i, i, i == 15);
            if (i == 4) idle(2);
        end
        drain("t1", 1240, 15);

        // two frames back to back, then a gapped check of each
        send(1, 1, 0); send(2, 2, 0); send(3, 3, 1);
        send(2, 2, 0); send(2, 2, 1);
        drain("t2_b2b", 8, 5);
        send(1, 1, 0); send(2, 2, 0); send(3, 3, 1);
        drain("t2_f1", 14, 3);
        send(2, 2, 0); send(2, 2, 1);
        drain("t2_f2", 8, 2);

        // 4-cycle stall mid-frame
        for (int i = 1; i <= 15; i++) begin
            send(i, i, i == 15);
            if (i == 7) stall(4);
        end
        drain("t3", 1240, 15);

        // signed extremes
        send(-128, -128, 0);
        send(-128, 127, 1);
        drain("t4", 128, 2);

        // accumulator overflow
        for (int i = 0; i < 20; i++) send(127, 127, i == 19);
        drain("t5", OVF_EXP, 20);

        // reset mid-frame
        for (int i = 1; i <= 5; i++) send(i, 3, 0);
        do_reset();
        send(1, 1, 0); send(2, 2, 0); send(3, 3, 1);
        drain("t6", 14, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
